// File: rtl/rob_phase_sequencer_if.sv
// Event stream from the phase sequencer to the simulation event logger.
// The master drives the event fields and valid; the slave returns ready.
interface rob_phase_sequencer_if #(
  parameter int LANE_W = 1,
  parameter int CNT_W  = 32
);
  logic              evt_valid;
  logic              evt_ready;
  logic [3:0]        evt_code;
  logic [LANE_W-1:0] evt_lane;
  logic [CNT_W-1:0]  evt_time;
  logic [CNT_W-1:0]  evt_duration;

  modport master (
    output evt_valid, evt_code, evt_lane, evt_time, evt_duration,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_code, evt_lane, evt_time, evt_duration,
    output evt_ready
  );
endinterface

// File: rtl/rob_phase_sequencer.sv
// ROB phase-marker sequencer: decodes fuzzing phase markers on every commit
// lane, tracks open phases, and serializes timestamped events in program order
// into a single valid/ready stream through an event FIFO.
// Optional watchdog on open phases: define ROBSEQ_WATCHDOG_EN.
//
// Per-phase state (one instance per phase 0..6):
//   state  | meaning
//   CLOSED | phase not running; END here is an orphan (error 1/2 code 2)
//   OPEN   | phase running since start_time; START here re-latches (code 1)
module rob_phase_sequencer #(
  parameter int LANES      = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 100000
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic [LANES-1:0]      commit_valid_i,
  input  logic [32*LANES-1:0]   commit_inst_i,
  rob_phase_sequencer_if.master evt,
  output logic [6:0]            phase_open_o,
  output logic                  err_valid_o,
  output logic [1:0]            err_code_o,
  output logic [3:0]            err_marker_o,
  output logic [15:0]           drop_cnt_o,
  output logic                  wdog_fire_o
);

  localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int NPH = 7;

  typedef enum logic {CLOSED = 1'b0, OPEN = 1'b1} phase_st_t;

  typedef struct packed {
    logic [3:0]       code;
    logic [LW-1:0]    lane;
    logic [CNT_W-1:0] tm;
    logic [CNT_W-1:0] dur;
  } evt_t;

  logic [CNT_W-1:0] cnt_q;
  phase_st_t        ph_q [NPH];
  phase_st_t        ph_d [NPH];
  logic [CNT_W-1:0] st_q [NPH];
  logic [CNT_W-1:0] st_d [NPH];

  evt_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;

  logic             err_valid_q;
  logic [1:0]       err_code_q;
  logic [3:0]       err_marker_q;
  logic [15:0]      drop_q;
  logic [16:0]      drop_sum;

  logic             pop;
  int               space;
  int               npush;
  int               ndrop;
  logic [LANES-1:0] push_en;
  logic [AW-1:0]    push_idx [LANES];
  evt_t             push_ent [LANES];
  logic             err_hit;
  logic [1:0]       err_code_d;
  logic [3:0]       err_marker_d;

  logic [31:0]      inst;
  logic [3:0]       k;
  logic [2:0]       p;
  logic [1:0]       lerr;
  logic [CNT_W-1:0] dur_v;

  // Decode markers lane by lane, walking phase state in program order and
  // allocating FIFO slots while space remains; the first lane error wins.
  always_comb begin
    pop          = (count_q != '0) && evt.evt_ready;
    space        = FIFO_DEPTH - int'(count_q) + (pop ? 1 : 0);
    ph_d         = ph_q;
    st_d         = st_q;
    npush        = 0;
    ndrop        = 0;
    err_hit      = 1'b0;
    err_code_d   = '0;
    err_marker_d = '0;
    inst         = '0;
    k            = '0;
    p            = '0;
    lerr         = '0;
    dur_v        = '0;
    for (int i = 0; i < LANES; i++) begin
      push_en[i]  = 1'b0;
      push_idx[i] = '0;
      push_ent[i] = '0;
      inst        = commit_inst_i[32*i +: 32];
      if (commit_valid_i[i] && inst[19:0] == 20'h02013 && inst[31:20] < 12'd14) begin
        k     = inst[23:20];
        p     = k[3:1];
        lerr  = 2'd0;
        dur_v = '0;
        if (!k[0]) begin
          if (ph_d[p] == OPEN) lerr = 2'd1;
          ph_d[p] = OPEN;
          st_d[p] = cnt_q;
        end else if (ph_d[p] == OPEN) begin
          dur_v   = cnt_q - st_d[p];
          ph_d[p] = CLOSED;
        end else begin
          lerr = 2'd2;
        end
        if (npush < space) begin
          push_en[i]  = 1'b1;
          push_idx[i] = wr_ptr_q + AW'(npush);
          push_ent[i] = '{code: k, lane: LW'(i), tm: cnt_q, dur: dur_v};
          npush++;
        end else begin
          ndrop++;
          if (lerr == 2'd0) lerr = 2'd3;
        end
        if (lerr != 2'd0 && !err_hit) begin
          err_hit      = 1'b1;
          err_code_d   = lerr;
          err_marker_d = k;
        end
      end
    end
  end

  assign drop_sum = {1'b0, drop_q} + 17'(ndrop);

  // Cycle counter, per-phase FSMs with start times, first-error capture, drops
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q        <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      err_marker_q <= '0;
      drop_q       <= '0;
      for (int j = 0; j < NPH; j++) begin
        ph_q[j] <= CLOSED;
        st_q[j] <= '0;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
      ph_q  <= ph_d;
      st_q  <= st_d;
      if (!err_valid_q && err_hit) begin
        err_valid_q  <= 1'b1;
        err_code_q   <= err_code_d;
        err_marker_q <= err_marker_d;
      end
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Event FIFO storage and pointers; head entry feeds the stream directly
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push_en[i]) mem_q[push_idx[i]] <= push_ent[i];
      end
      wr_ptr_q <= wr_ptr_q + AW'(npush);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_q + CW'(npush) - CW'(pop);
    end
  end

  assign evt.evt_valid    = (count_q != '0);
  assign evt.evt_code     = mem_q[rd_ptr_q].code;
  assign evt.evt_lane     = mem_q[rd_ptr_q].lane;
  assign evt.evt_time     = mem_q[rd_ptr_q].tm;
  assign evt.evt_duration = mem_q[rd_ptr_q].dur;

  // Phase-open vector straight from the per-phase state registers
  always_comb begin
    phase_open_o = '0;
    for (int j = 0; j < NPH; j++) phase_open_o[j] = (ph_q[j] == OPEN);
  end

  assign err_valid_o  = err_valid_q;
  assign err_code_o   = err_code_q;
  assign err_marker_o = err_marker_q;
  assign drop_cnt_o   = drop_q;

`ifdef ROBSEQ_WATCHDOG_EN
  logic [NPH-1:0] wdog_hit;
  logic           wdog_q;

  // One comparator per phase: open too long since its latest START
  always_comb begin
    wdog_hit = '0;
    for (int j = 0; j < NPH; j++)
      wdog_hit[j] = (ph_q[j] == OPEN) && ((cnt_q - st_q[j]) >= CNT_W'(WDOG_LIMIT));
  end

  // Sticky watchdog flag, cleared only by reset
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) wdog_q <= 1'b0;
    else           wdog_q <= wdog_q | (|wdog_hit);
  end

  assign wdog_fire_o = wdog_q;
`else
  assign wdog_fire_o = 1'b0;
`endif

endmodule
